// File: rtl/dispatch_packer.sv
// Dispatch packer: 8-entry FIFO that gathers renamed uops into groups of four.
// Define DISPATCH_PACK_PARTIAL_EN to also flush partial groups after TIMEOUT idle cycles.
module dispatch_packer #(
   parameter int WIDTH_REG = 6,
   parameter int WIDTH_TAG = 5,
   parameter int WIDTH_BRM = 4,
   parameter int TIMEOUT   = 4,
   localparam int WIDTH = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [WIDTH-1:0]       i_inst1,
   input  logic [WIDTH-1:0]       i_inst2,
   input  logic                   i_valid1,
   input  logic                   i_valid2,
   output logic                   o_ready,
   input  logic [4*WIDTH_REG-1:0] i_wdest4x,
   input  logic [WIDTH_BRM-1:0]   i_BrKill,
   input  logic                   i_stall,
   output logic [WIDTH-1:0]       o_inst1,
   output logic [WIDTH-1:0]       o_inst2,
   output logic [WIDTH-1:0]       o_inst3,
   output logic [WIDTH-1:0]       o_inst4,
   output logic                   o_en
);

   localparam int PR1_LSB = 3;
   localparam int PR2_LSB = 3 + WIDTH_REG;
   localparam int BRM_LSB = 3 + 3*WIDTH_REG + WIDTH_TAG;

   typedef logic [WIDTH-1:0] inst_t;

   inst_t      mem_q [8];
   inst_t      mem_d [8];
   inst_t      cur   [8];
   inst_t      out_q [4];
   inst_t      out_d [4];
   inst_t      in1, in2;
   logic [2:0] head_q, head_d;
   logic [2:0] tail_q, tail_d;
   logic [3:0] count_q, count_d;
   logic       en_q, en_d;
   logic       ready, push1, push2, pop4;
   logic [1:0] npush;
   logic [2:0] popn;
   logic [2:0] idx;

   // Operand wakeup and branch kill applied to one entry.
   function automatic inst_t upd(input inst_t e,
                                 input logic [4*WIDTH_REG-1:0] wd,
                                 input logic [WIDTH_BRM-1:0] kill);
      inst_t r;
      r = e;
      for (int k = 0; k < 4; k++) begin
         if (e[PR1_LSB +: WIDTH_REG] == wd[k*WIDTH_REG +: WIDTH_REG])
            r[0] = 1'b1;
         if (e[PR2_LSB +: WIDTH_REG] == wd[k*WIDTH_REG +: WIDTH_REG])
            r[1] = 1'b1;
      end
      if ((e[BRM_LSB +: WIDTH_BRM] & kill) != '0)
         r[2] = 1'b0;
      return r;
   endfunction

`ifdef DISPATCH_PACK_PARTIAL_EN
   localparam int IW = $clog2(TIMEOUT + 1);
   logic [IW-1:0] idle_q, idle_d;
   logic          flush;

   assign flush = (idle_q == IW'(TIMEOUT)) && (count_q >= 4'd1) &&
                  (count_q <= 4'd3) && !i_stall;

   always_comb begin
      idle_d = idle_q;
      if ((npush != 2'd0) || (popn != 3'd0))
         idle_d = '0;
      else if ((count_q >= 4'd1) && (count_q <= 4'd3) && !i_stall &&
               (idle_q != IW'(TIMEOUT)))
         idle_d = idle_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         idle_q <= '0;
      else
         idle_q <= idle_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_comb begin
      ready = (count_q <= 4'd6);
      push1 = ready & i_valid1;
      push2 = ready & i_valid2;
      npush = {1'b0, push1} + {1'b0, push2};
      pop4  = (count_q >= 4'd4) && !i_stall;
      popn  = pop4 ? 3'd4 : 3'd0;
`ifdef DISPATCH_PACK_PARTIAL_EN
      if (!pop4 && flush)
         popn = count_q[2:0];
`endif
      in1 = upd(i_inst1, i_wdest4x, i_BrKill);
      in2 = upd(i_inst2, i_wdest4x, i_BrKill);
      for (int i = 0; i < 8; i++) begin
         cur[i]   = upd(mem_q[i], i_wdest4x, i_BrKill);
         mem_d[i] = cur[i];
      end
      if (push1)
         mem_d[tail_q] = in1;
      if (push2)
         mem_d[tail_q + {2'b00, push1}] = in2;
      tail_d  = tail_q + {1'b0, npush};
      head_d  = head_q + popn;
      count_d = count_q + {2'b00, npush} - {1'b0, popn};
      en_d    = (popn != 3'd0);
      idx     = head_q;
      for (int k = 0; k < 4; k++) begin
         out_d[k] = out_q[k];
         if (en_d) begin
            idx      = head_q + 3'(k);
            out_d[k] = (3'(k) < popn) ? cur[idx] : '0;
         end
      end
   end

   // Payload needs no reset: count=0 marks every slot empty.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < 8; i++)
         mem_q[i] <= mem_d[i];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         en_q    <= 1'b0;
         for (int k = 0; k < 4; k++)
            out_q[k] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         en_q    <= en_d;
         for (int k = 0; k < 4; k++)
            out_q[k] <= out_d[k];
      end
   end

   assign o_ready = ready;
   assign o_en    = en_q;
   assign o_inst1 = out_q[0];
   assign o_inst2 = out_q[1];
   assign o_inst3 = out_q[2];
   assign o_inst4 = out_q[3];

endmodule

// File: tb/tb_dispatch_packer.sv
// Scoreboard bench for dispatch_packer: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_dispatch_packer;

   localparam int WR = 6;
   localparam int WT = 5;
   localparam int WB = 4;
   localparam int TO = 4;
   localparam int W  = 7 + WB + WT + 3*WR + 3;
   localparam int GW = 4*W;
`ifdef DISPATCH_PACK_PARTIAL_EN
   localparam bit PART = 1'b1;
`else
   localparam bit PART = 1'b0;
`endif
   localparam logic [4*WR-1:0] NOWD = {4{6'd63}};

   typedef logic [W-1:0] inst_t;
   typedef struct {
      logic [GW-1:0] grp;
      int            due;
   } exp_t;

   logic            clk = 1'b0;
   logic            i_rst = 1'b1;
   inst_t           i_inst1 = '0, i_inst2 = '0;
   logic            i_valid1 = 1'b0, i_valid2 = 1'b0;
   logic            o_ready;
   logic [4*WR-1:0] i_wdest4x = NOWD;
   logic [WB-1:0]   i_BrKill = '0;
   logic            i_stall = 1'b0;
   inst_t           o_inst1, o_inst2, o_inst3, o_inst4;
   logic            o_en;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            idle = 0;
   inst_t         mq[$];
   exp_t          exp_q[$];
   logic [GW-1:0] last = '0;
   logic          prev_rst = 1'b1;
   logic          exp_en;
   exp_t          em;

   dispatch_packer #(
      .WIDTH_REG(WR), .WIDTH_TAG(WT), .WIDTH_BRM(WB), .TIMEOUT(TO)
   ) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_inst1(i_inst1), .i_inst2(i_inst2),
      .i_valid1(i_valid1), .i_valid2(i_valid2),
      .o_ready(o_ready), .i_wdest4x(i_wdest4x),
      .i_BrKill(i_BrKill), .i_stall(i_stall),
      .o_inst1(o_inst1), .o_inst2(o_inst2),
      .o_inst3(o_inst3), .o_inst4(o_inst4),
      .o_en(o_en)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [GW-1:0] act,
                      input logic [GW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic inst_t mk(input logic [6:0] u, input logic [WB-1:0] bm,
                                input logic [WT-1:0] tg, input logic [WR-1:0] rd,
                                input logic [WR-1:0] r2, input logic [WR-1:0] r1,
                                input logic v, input logic q2, input logic q1);
      return {u, bm, tg, rd, r2, r1, v, q2, q1};
   endfunction

   // Reference rule: a source becomes ready when its register is broadcast;
   // a uop on a killed branch path loses its valid bit.
   function automatic inst_t mupd(input inst_t e, input logic [4*WR-1:0] wd,
                                  input logic [WB-1:0] kl);
      logic [WR-1:0] r1, r2;
      logic [WB-1:0] bm;
      inst_t         r;
      r  = e;
      r1 = e[3 +: WR];
      r2 = e[3+WR +: WR];
      bm = e[3+3*WR+WT +: WB];
      for (int k = 0; k < 4; k++) begin
         if (r1 == wd[k*WR +: WR]) r[0] = 1'b1;
         if (r2 == wd[k*WR +: WR]) r[1] = 1'b1;
      end
      if ((bm & kl) != '0) r[2] = 1'b0;
      return r;
   endfunction

   function automatic inst_t rndi();
      return W'({$urandom(), $urandom()});
   endfunction

   task automatic cycle(input logic v1, input logic v2, input inst_t a,
                        input inst_t b, input logic st,
                        input logic [4*WR-1:0] wd, input logic [WB-1:0] kl,
                        input logic rs);
      int            np;
      int            popn;
      logic          rdy;
      logic [GW-1:0] g;
      exp_t          e;
      @(posedge clk);
      #1;
      i_valid1  = v1;
      i_valid2  = v2;
      i_inst1   = a;
      i_inst2   = b;
      i_stall   = st;
      i_wdest4x = wd;
      i_BrKill  = kl;
      i_rst     = rs;
      if (rs) begin
         mq.delete();
         idle = 0;
         return;
      end
      rdy = (mq.size() <= 6);
      chk("o_ready", GW'(o_ready), GW'(rdy));
      foreach (mq[i]) mq[i] = mupd(mq[i], wd, kl);
      popn = 0;
      if (mq.size() >= 4 && !st)
         popn = 4;
      else if (PART && idle == TO && mq.size() >= 1 && mq.size() <= 3 && !st)
         popn = mq.size();
      if (popn > 0) begin
         g = '0;
         for (int k = 0; k < popn; k++) g[k*W +: W] = mq.pop_front();
         e.grp = g;
         e.due = cyc + 1;
         exp_q.push_back(e);
      end
      np = 0;
      if (rdy && v1) begin mq.push_back(mupd(a, wd, kl)); np++; end
      if (rdy && v2) begin mq.push_back(mupd(b, wd, kl)); np++; end
      if (np > 0 || popn > 0)
         idle = 0;
      else if (mq.size() >= 1 && mq.size() <= 3 && !st && idle < TO)
         idle++;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, '0, '0, 1'b0, NOWD, '0, 1'b0);
   endtask

   task automatic push(input logic v1, input logic v2, input inst_t a,
                       input inst_t b);
      cycle(v1, v2, a, b, 1'b0, NOWD, '0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (prev_rst) last = '0;
      exp_en = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("o_en", GW'(o_en), GW'(exp_en));
      if (exp_en) begin
         em = exp_q.pop_front();
         chk("group", {o_inst4, o_inst3, o_inst2, o_inst1}, em.grp);
         last = em.grp;
      end else begin
         chk("hold", {o_inst4, o_inst3, o_inst2, o_inst1}, last);
      end
      prev_rst = i_rst;
   end

   initial begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, NOWD, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, '0, 1'b0, NOWD, '0, 1'b1);
      idle_n(1);
      chk("rst_ready", GW'(o_ready), GW'(1'b1));
      chk("rst_en", GW'(o_en), '0);
      chk("rst_inst", {o_inst4, o_inst3, o_inst2, o_inst1}, '0);

      // full group of four
      push(1, 1, mk(7'h11, 4'h0, 5'd1, 6'd10, 6'd11, 6'd12, 1, 0, 0),
                 mk(7'h12, 4'h0, 5'd2, 6'd13, 6'd14, 6'd15, 1, 0, 0));
      push(1, 1, mk(7'h13, 4'h0, 5'd3, 6'd16, 6'd17, 6'd18, 1, 0, 0),
                 mk(7'h14, 4'h0, 5'd4, 6'd19, 6'd20, 6'd21, 1, 0, 0));
      idle_n(4);

      // fill while stalled, excess dropped
      for (int i = 0; i < 5; i++)
         cycle(1, 1, rndi(), rndi(), 1'b1, NOWD, '0, 1'b0);
      idle_n(5);

      // wakeup on lane 2
      push(1, 1, mk(7'h21, 4'h0, 5'd5, 6'd30, 6'd7, 6'd5, 1, 0, 0),
                 mk(7'h22, 4'h0, 5'd6, 6'd31, 6'd8, 6'd9, 1, 0, 0));
      cycle(0, 0, '0, '0, 1'b0, {6'd63, 6'd5, 6'd63, 6'd63}, '0, 1'b0);
      push(1, 1, mk(7'h23, 4'h0, 5'd7, 6'd32, 6'd33, 6'd34, 1, 0, 0),
                 mk(7'h24, 4'h0, 5'd8, 6'd35, 6'd36, 6'd37, 1, 0, 0));
      idle_n(4);

      // kill on branch mask bit 1
      push(1, 1, mk(7'h31, 4'b0010, 5'd9, 6'd40, 6'd41, 6'd42, 1, 1, 1),
                 mk(7'h32, 4'b0001, 5'd10, 6'd43, 6'd44, 6'd45, 1, 1, 0));
      cycle(0, 0, '0, '0, 1'b0, NOWD, 4'b0010, 1'b0);
      push(1, 1, mk(7'h33, 4'b0100, 5'd11, 6'd46, 6'd47, 6'd48, 1, 0, 1),
                 mk(7'h34, 4'b0010, 5'd12, 6'd49, 6'd50, 6'd51, 1, 0, 0));
      idle_n(4);

      // three then idle: partial flush only when enabled
      push(1, 1, rndi(), rndi());
      push(0, 1, '0, rndi());
      idle_n(10);
      push(1, 0, rndi(), '0);
      idle_n(10);

      // reset with entries in flight
      push(1, 1, rndi(), rndi());
      push(1, 0, rndi(), '0);
      cycle(0, 0, '0, '0, 1'b0, NOWD, '0, 1'b1);
      push(1, 1, rndi(), rndi());
      push(1, 1, rndi(), rndi());
      idle_n(4);

      for (int n = 0; n < 400; n++) begin
         logic [WB-1:0] kl;
         kl = ($urandom_range(0, 7) == 0) ? WB'(1 << $urandom_range(0, WB-1)) : '0;
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               rndi(), rndi(), ($urandom_range(0, 3) == 0),
               (4*WR)'($urandom()), kl, ($urandom_range(0, 99) == 0));
      end
      idle_n(12);
      chk("drain", GW'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
